// File: rtl/resp_sig_compactor.sv
// Response signature compactor: folds each valid response vector into a
// 32-bit MISR over a programmed window and hands back the result via valid/ready.
module resp_sig_compactor #(
    parameter int                DATA_W = 159,
    parameter int                SIG_W  = 32,
    parameter logic [SIG_W-1:0]  POLY   = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]  SEED   = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       win_len,
    input  logic [SIG_W-1:0]  exp_sig,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              sig_valid,
    input  logic              rd_ready,
    output logic [SIG_W-1:0]  sig,
    output logic [31:0]       cycle_count,
    output logic              match
);

    localparam int NCH = (DATA_W + SIG_W - 1) / SIG_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        len_q, len_d;
    logic [SIG_W-1:0]   exp_q, exp_d;
    logic               match_q, match_d;

    logic [NCH*SIG_W-1:0] pad;
    logic [SIG_W-1:0]     fold;
    logic [SIG_W-1:0]     sig_step;
    logic [31:0]          cnt_inc;

    // Top chunk is zero-padded, so bits above DATA_W alias onto nothing
    always_comb begin
        pad = '0;
        pad[DATA_W-1:0] = in_data;
        fold = '0;
        for (int i = 0; i < NCH; i++) begin
            fold = fold ^ pad[i*SIG_W +: SIG_W];
        end
    end

    assign sig_step = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ fold;
    assign cnt_inc  = cnt_q + 32'd1;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        exp_d   = exp_q;
        match_d = match_q;
        unique case (state_q)
            IDLE, RUN: begin
                // A start in RUN restarts the window and drops this cycle's sample
                if (start) begin
                    state_d = RUN;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    len_d   = (win_len == 32'd0) ? 32'd1 : win_len;
                    exp_d   = exp_sig;
                    match_d = 1'b0;
                end else if (state_q == RUN && in_valid) begin
                    sig_d = sig_step;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = DONE;
                        match_d = (sig_step == exp_q);
                    end
                end
            end
            DONE: begin
                if (rd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            len_q   <= 32'd1;
            exp_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            exp_q   <= exp_d;
            match_q <= match_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign sig_valid   = (state_q == DONE);
    assign sig         = sig_q;
    assign cycle_count = cnt_q;
    assign match       = match_q;

endmodule

// File: tb/tb_resp_sig_compactor.sv
// Scoreboard bench for resp_sig_compactor: directed corner windows plus
// randomized windows against a behavioural MISR model.
module tb_resp_sig_compactor;

    localparam int          DW   = 159;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   win_len = '0;
    logic [31:0]   exp_sig = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          busy;
    logic          sig_valid;
    logic          rd_ready = 1'b0;
    logic [31:0]   sig;
    logic [31:0]   cycle_count;
    logic          match;

    resp_sig_compactor #(.DATA_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .win_len(win_len),
        .exp_sig(exp_sig),
        .in_valid(in_valid),
        .in_data(in_data),
        .busy(busy),
        .sig_valid(sig_valid),
        .rd_ready(rd_ready),
        .sig(sig),
        .cycle_count(cycle_count),
        .match(match)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic [31:0] c;
        logic        m;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Spec-level model: every set bit i of the vector toggles signature bit i mod 32
    function automatic logic [31:0] model_step(logic [31:0] s, logic [DW-1:0] d);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < DW; i++) begin
            if (d[i]) f = f ^ (32'd1 << (i % 32));
        end
        return (s << 1) ^ (s[31] ? POLY : 32'd0) ^ f;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && sig_valid && rd_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: result seen with no expectation");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_sig", sig, e.s);
                chk("mon_count", cycle_count, e.c);
                chk("mon_match", {31'd0, match}, {31'd0, e.m});
            end
        end
    end

    // exp_mode: 0 given, 1 model-correct, 2 random. mode: 0 random, 1 fixed all-valid, 2 alternating.
    task automatic window(input logic [31:0] len, input int exp_mode,
                          input logic [31:0] exp_given, input int mode,
                          input logic [DW-1:0] fixed, input int bp);
        logic          vq[$];
        logic [DW-1:0] dq[$];
        logic          v;
        logic [DW-1:0] d;
        logic [31:0]   s, e;
        int            eff, n, i;
        eff = (len == 0) ? 1 : int'(len);
        s = SEED;
        n = 0;
        i = 0;
        while (n < eff && i < 400) begin
            v = (mode == 1) ? 1'b1 : (mode == 2) ? (i % 2 == 0) : ($urandom_range(0, 9) < 6);
            d = (mode == 1) ? fixed : rand_data();
            vq.push_back(v);
            dq.push_back(d);
            if (v) begin
                s = model_step(s, d);
                n++;
            end
            i++;
        end
        e = (exp_mode == 0) ? exp_given : (exp_mode == 1) ? s : $urandom;
        start = 1'b1;
        win_len = len;
        exp_sig = e;
        in_valid = 1'b1;
        in_data = rand_data();
        cyc();
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_count", cycle_count, 32'd0);
        chk("start_sig", sig, SEED);
        for (int k = 0; k < vq.size(); k++) begin
            in_valid = vq[k];
            in_data = dq[k];
            cyc();
            if (k < vq.size() - 1) chk("run_busy", {31'd0, busy}, 32'd1);
        end
        in_valid = 1'b0;
        chk("done_valid", {31'd0, sig_valid}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        sb.push_back('{s: s, c: n, m: (s == e)});
        for (int b = 0; b < bp; b++) begin
            if (b == bp / 2) begin
                start = 1'b1;
                win_len = $urandom_range(1, 4);
                exp_sig = $urandom;
            end
            cyc();
            start = 1'b0;
            chk("bp_valid", {31'd0, sig_valid}, 32'd1);
            chk("bp_sig", sig, s);
        end
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        chk("hs_valid", {31'd0, sig_valid}, 32'd0);
        chk("hs_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] fx;
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, sig_valid}, 32'd0);
        chk("rst_sig", sig, 32'd0);
        chk("rst_count", cycle_count, 32'd0);
        chk("rst_match", {31'd0, match}, 32'd0);
        rst = 1'b0;
        cyc();

        window(32'd1, 0, 32'hFB3EE249, 1, '0, 0);
        chk("zero_sig", sig, 32'hFB3EE249);
        chk("zero_count", cycle_count, 32'd1);

        fx = '0;
        fx[0] = 1'b1;
        window(32'd1, 0, 32'hFB3EE248, 1, fx, 0);
        chk("bit0_sig", sig, 32'hFB3EE248);
        fx = '0;
        fx[128] = 1'b1;
        window(32'd1, 0, 32'hFB3EE248, 1, fx, 0);
        chk("bit128_sig", sig, 32'hFB3EE248);

        window(32'd3, 1, 32'd0, 2, '0, 0);
        chk("gap_count", cycle_count, 32'd3);

        window(32'd4, 2, 32'd0, 0, '0, 10);

        start = 1'b1;
        win_len = 32'd5;
        exp_sig = '0;
        cyc();
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            in_data = rand_data();
            cyc();
        end
        rst = 1'b1;
        cyc();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_sig", sig, 32'd0);
        chk("mid_rst_count", cycle_count, 32'd0);
        chk("mid_rst_valid", {31'd0, sig_valid}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        cyc();
        window(32'd5, 1, 32'd0, 0, '0, 0);

        start = 1'b1;
        win_len = 32'd6;
        cyc();
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            in_data = rand_data();
            cyc();
        end
        window(32'd3, 1, 32'd0, 0, '0, 0);

        window(32'd0, 1, 32'd0, 1, rand_data(), 0);
        chk("len0_count", cycle_count, 32'd1);

        for (int r = 0; r < 20; r++) begin
            window($urandom_range(0, 8), $urandom_range(0, 2), $urandom, 0, '0,
                   $urandom_range(0, 4));
        end

        repeat (3) cyc();
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/resp_sig_compactor.md
# resp_sig_compactor

Captures the DUT response stream cycle by cycle and compacts it into a 32-bit multiple-input signature (MISR) over a programmed window of valid cycles. It is the receiving end of the stimulus path: the stimulus side drives the flat input vector, and this block consumes the flat output vector. It then presents a final signature, a cycle count and a pass/fail compare against an expected signature through a valid/ready readout handshake. It sits between the DUT output bus and the self-check/readout logic, so regression compares one word instead of full per-cycle traces.

## Interface
Parameters:
- DATA_W, 159, width of the captured response vector
- SIG_W, 32, signature width (fixed at 32; other values unsupported)
- POLY, 32'h04C11DB7, MISR feedback polynomial
- SEED, 32'hFFFFFFFF, signature value loaded on start

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: arm a new capture window
- win_len  in  32  number of valid cycles to absorb; sampled on start; 0 treated as 1
- exp_sig  in  32  expected signature; sampled on start
- in_valid  in  1  in_data is a response sample this cycle
- in_data  in  DATA_W  flat DUT response vector
- busy  out  1  high in RUN
- sig_valid  out  1  result available (DONE)
- rd_ready  in  1  consumer accepts result
- sig  out  32  current/final signature
- cycle_count  out  32  samples absorbed in the current/last window
- match  out  1  sig == exp_sig, valid while sig_valid

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE: if start, then sig<=SEED, cycle_count<=0, latch win_len (0 becomes 1) and exp_sig, and go to RUN.
- RUN: each cycle with in_valid, absorb in_data and increment cycle_count. On the absorb where cycle_count+1 == latched length, go to DONE.
- DONE: sig_valid=1, with sig, cycle_count and match held stable. When sig_valid && rd_ready, go to IDLE. start in DONE is ignored until the handshake completes.
- start in RUN restarts the window: reload SEED, clear the count, relatch the inputs, and discard any in_valid in that cycle.
- Fold: split in_data into 32-bit chunks from bit 0 upward. Zero-pad the top chunk (bits [158:128] give 31 bits plus a 0 MSB). XOR all chunks to form F.
- Update: sig_next = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ F.
- cycle_count wraps modulo 2^32. No saturation is needed, since it cannot exceed win_len.
- match is registered on the transition into DONE.

## Timing
- Reset (rst high at an edge): state IDLE, busy=0, sig_valid=0, sig=0, cycle_count=0, match=0. Reset has priority over every other input in every state, including mid-RUN and DONE.
- start sampled at edge k: busy=1 from k+1. The first in_valid that can be absorbed is the one sampled at edge k+1.
- Final absorb at edge m: sig_valid=1 and busy=0 from m+1.
- Latency from final sample to result is 1 cycle.
- Handshake at edge h (sig_valid && rd_ready): sig_valid=0 from h+1. sig and cycle_count keep their final values in IDLE until the next start or reset.
- in_valid is ignored in IDLE and DONE.
- Gaps in in_valid stall the window without changing sig.

## Test plan
- Zero response, win_len=1, in_data=0 with one valid cycle -> sig_valid one cycle later, sig=32'hFB3EE249, cycle_count=1. With exp_sig=32'hFB3EE249, match=1.
- Fold aliasing, win_len=1: in_data with only bit 0 set -> sig=32'hFB3EE248. Repeat with only bit 128 set -> identical 32'hFB3EE248.
- Gapped valid, win_len=3 with 7 cycles of alternating in_valid -> cycle_count=3. sig equals a reference-model MISR over the 3 valid samples only. busy stays high until the third valid sample.
- Backpressure: hold rd_ready=0 for 10 cycles in DONE and pulse start meanwhile -> sig_valid stays 1, sig stable, start ignored. rd_ready=1 -> IDLE next cycle.
- Reset mid-RUN: after 2 of 5 samples assert rst -> next cycle all outputs 0, state IDLE. A fresh start then yields the same signature as a clean run.
- Restart and win_len=0: start during RUN -> count back to 0 and sig=SEED next cycle. win_len=0 completes after exactly 1 valid sample.
